lcd_pixel_scheduler: RTL and testbench



---
 rtl/lcd_pixel_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_lcd_pixel_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_scheduler.sv
// lcd_pixel_scheduler
// Buffers PPU pixels in a small FIFO and feeds them to the 8-bit ILI9341 driver
// at no more than one pixel every PIX_CYCLES clocks. Each frame starts on a PPU
// vblank fall. Frames that end early are resynchronised, and overflow/underflow
// are reported as sticky flags.
module lcd_pixel_scheduler #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int PIX_CYCLES = 4,
    parameter int FIFO_AW    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       initialized,
    input  logic       pix_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       pix_vblank,
    input  logic       clr_err,
    output logic       lcd_write,
    output logic [7:0] lcd_col_r,
    output logic [7:0] lcd_col_g,
    output logic [7:0] lcd_col_b,
    output logic       lcd_vblank,
    output logic       frame_active,
    output logic       overflow,
    output logic       underflow,
    output logic [7:0] frame_cnt
);

    localparam int XW    = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int YW    = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
    localparam int PW    = (PIX_CYCLES > 1) ? $clog2(PIX_CYCLES) : 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [XW-1:0]      X_LAST      = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]      Y_LAST      = YW'(SCREEN_H - 1);
    localparam logic [XW-1:0]      X_ONE       = XW'(1'b1);
    localparam logic [YW-1:0]      Y_ONE       = YW'(1'b1);
    localparam logic [PW-1:0]      PACE_RELOAD = PW'(PIX_CYCLES - 1);
    localparam logic [PW-1:0]      PACE_ONE    = PW'(1'b1);
    localparam logic [FIFO_AW-1:0] PTR_ONE     = FIFO_AW'(1'b1);
    localparam logic [CW-1:0]      CNT_ONE     = CW'(1'b1);
    localparam logic [CW-1:0]      CNT_FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_WAIT_INIT   = 2'd0,
        ST_WAIT_VBL    = 2'd1,
        ST_WAIT_ACTIVE = 2'd2,
        ST_STREAM      = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               vbl_q_r;
    logic [23:0]        fifo_mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [PW-1:0]      pace_r;
    logic [XW-1:0]      x_r;
    logic [YW-1:0]      y_r;

    logic               vbl_rise_s;
    logic               vbl_fall_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic               push_s;
    logic               pop_s;
    logic               accept_s;
    logic               drop_s;
    logic               last_pix_s;
    logic               flush_s;
    logic               frame_done_s;
    logic               short_frame_s;
    logic               clear_xy_s;
    logic [23:0]        head_s;

    assign vbl_rise_s   = pix_vblank & ~vbl_q_r;
    assign vbl_fall_s   = ~pix_vblank & vbl_q_r;
    assign fifo_empty_s = (count_r == '0);
    assign fifo_full_s  = (count_r == CNT_FULL);
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign last_pix_s   = (x_r == X_LAST) && (y_r == Y_LAST);

    // A write needs an initialised driver, a queued pixel and an expired pace timer.
    assign pop_s    = (state_r == ST_STREAM) & initialized & ~fifo_empty_s & (pace_r == '0);
    assign push_s   = (state_r == ST_STREAM) & pix_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept_s = push_s & (~fifo_full_s | pop_s);
    assign drop_s   = push_s & fifo_full_s & ~pop_s;
    // Every state except STREAM keeps the FIFO empty.
    assign flush_s  = (state_nxt_s != ST_STREAM);

    // Next-state decode: frame alignment, completion and short-frame resync.
    always_comb begin
        state_nxt_s   = state_r;
        frame_done_s  = 1'b0;
        short_frame_s = 1'b0;
        clear_xy_s    = 1'b0;
        if (!initialized) begin
            state_nxt_s = ST_WAIT_INIT;
        end else begin
            case (state_r)
                ST_WAIT_INIT: begin
                    state_nxt_s = ST_WAIT_VBL;
                end
                ST_WAIT_VBL: begin
                    if (vbl_rise_s) begin
                        state_nxt_s = ST_WAIT_ACTIVE;
                    end else begin
                        state_nxt_s = ST_WAIT_VBL;
                    end
                end
                ST_WAIT_ACTIVE: begin
                    if (vbl_fall_s) begin
                        state_nxt_s = ST_STREAM;
                        clear_xy_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_ACTIVE;
                    end
                end
                ST_STREAM: begin
                    if (pop_s && last_pix_s) begin
                        state_nxt_s  = ST_WAIT_VBL;
                        frame_done_s = 1'b1;
                    end else if (vbl_rise_s) begin
                        state_nxt_s   = ST_WAIT_ACTIVE;
                        short_frame_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end
                default: begin
                    state_nxt_s = ST_WAIT_INIT;
                end
            endcase
        end
    end

    // State register and the registered copy of vblank used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT_INIT;
            vbl_q_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            vbl_q_r <= pix_vblank;
        end
    end

    // FIFO storage: accepted pixels are written at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 24'd0;
            end
        end else if (accept_s) begin
            fifo_mem_r[wr_ptr_r] <= {pix_r, pix_g, pix_b};
        end
    end

    // FIFO pointers and occupancy; a flush discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Pace timer: reloads on each write and keeps draining in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pace_r <= '0;
        end else if (pop_s) begin
            pace_r <= PACE_RELOAD;
        end else if (pace_r != '0) begin
            pace_r <= pace_r - PACE_ONE;
        end
    end

    // Pixel position within the frame, advanced once per driver write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= '0;
            y_r <= '0;
        end else if (clear_xy_s) begin
            x_r <= '0;
            y_r <= '0;
        end else if (pop_s) begin
            if (x_r == X_LAST) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST) ? '0 : (y_r + Y_ONE);
            end else begin
                x_r <= x_r + X_ONE;
            end
        end
    end

    // Driver interface: one-cycle write strobe; colour held for the low-byte phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_write    <= 1'b0;
            lcd_col_r    <= 8'd0;
            lcd_col_g    <= 8'd0;
            lcd_col_b    <= 8'd0;
            lcd_vblank   <= 1'b1;
            frame_active <= 1'b0;
        end else begin
            lcd_write    <= pop_s;
            lcd_vblank   <= (state_nxt_s != ST_STREAM);
            frame_active <= (state_nxt_s == ST_STREAM);
            if (pop_s) begin
                lcd_col_r <= head_s[23:16];
                lcd_col_g <= head_s[15:8];
                lcd_col_b <= head_s[7:0];
            end
        end
    end

    // Status: completed-frame counter and sticky error flags (a new event beats clr_err).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (frame_done_s) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (short_frame_s) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_pixel_scheduler.sv
// Testbench for lcd_pixel_scheduler: a per-cycle table, directed multi-cycle
// sequences and randomised traffic, all checked against a queue-based reference model.
module tb_lcd_pixel_scheduler;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int PIX   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       initialized = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_r = 8'd0;
    logic [7:0] pix_g = 8'd0;
    logic [7:0] pix_b = 8'd0;
    logic       pix_vblank = 1'b1;
    logic       clr_err = 1'b0;
    logic       lcd_write;
    logic [7:0] lcd_col_r;
    logic [7:0] lcd_col_g;
    logic [7:0] lcd_col_b;
    logic       lcd_vblank;
    logic       frame_active;
    logic       overflow;
    logic       underflow;
    logic [7:0] frame_cnt;
    logic [23:0] col_s;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    logic [23:0] wr_q[$];
    int          wr_t[$];

    assign col_s = {lcd_col_r, lcd_col_g, lcd_col_b};

    always #5 clk = ~clk;

    lcd_pixel_scheduler #(
        .SCREEN_W(W), .SCREEN_H(H), .PIX_CYCLES(PIX), .FIFO_AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .initialized(initialized), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_vblank(pix_vblank),
        .clr_err(clr_err), .lcd_write(lcd_write), .lcd_col_r(lcd_col_r),
        .lcd_col_g(lcd_col_g), .lcd_col_b(lcd_col_b), .lcd_vblank(lcd_vblank),
        .frame_active(frame_active), .overflow(overflow), .underflow(underflow),
        .frame_cnt(frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic i, input logic v, input logic pv,
                         input logic [23:0] px, input logic c);
        initialized = i;
        pix_vblank  = v;
        pix_valid   = pv;
        pix_r       = px[23:16];
        pix_g       = px[15:8];
        pix_b       = px[7:0];
        clr_err     = c;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [23:0] rgb(input logic [7:0] v);
        return {v, v, v};
    endfunction

    // n pixels during active video, one every 'gap' cycles, values first, first+1, ...
    task automatic send_pixels(input logic [7:0] first, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, 1'b0, 1'b1, rgb(8'(first + k)), 1'b0);
            tick(1);
            drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0);
            tick(gap - 1);
        end
    endtask

    // ---------------- reference model ----------------
    // Pixels kept in a queue, pacing as an absolute "earliest next write" cycle,
    // frame progress as a plain pixel index.
    localparam int M_IDLE = 0, M_ARMED = 1, M_READY = 2, M_STREAM = 3;
    int          m_mode = M_IDLE;
    logic [23:0] mq[$];
    longint      m_cyc = 0;
    longint      m_next_ok = 0;
    int          m_idx = 0;
    logic        m_vbl_prev = 1'b1;
    logic        m_wr = 1'b0;
    logic [23:0] m_col = 24'd0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    logic [7:0]  m_frames = 8'd0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE; mq.delete(); m_cyc = 0; m_next_ok = 0; m_idx = 0;
                m_vbl_prev = 1'b1; m_wr = 1'b0; m_col = 24'd0;
                m_ovf = 1'b0; m_unf = 1'b0; m_frames = 8'd0;
            end else begin
                bit rise, fall, wr, s_ovf, s_unf;
                int pre;
                rise = pix_vblank && !m_vbl_prev;
                fall = !pix_vblank && m_vbl_prev;
                pre = mq.size();
                wr = (m_mode == M_STREAM) && initialized && (pre > 0) && (m_cyc >= m_next_ok);
                s_ovf = 1'b0;
                s_unf = 1'b0;
                if (wr) begin
                    m_col = mq.pop_front();
                    m_next_ok = m_cyc + PIX;
                    m_idx++;
                end
                if (m_mode == M_STREAM && pix_valid) begin
                    if (pre < DEPTH || wr) mq.push_back({pix_r, pix_g, pix_b});
                    else s_ovf = 1'b1;
                end
                if (!initialized) begin
                    m_mode = M_IDLE;
                    mq.delete();
                end else if (m_mode == M_IDLE) begin
                    m_mode = M_ARMED;
                end else if (m_mode == M_ARMED) begin
                    if (rise) m_mode = M_READY;
                end else if (m_mode == M_READY) begin
                    if (fall) begin m_mode = M_STREAM; m_idx = 0; end
                end else begin
                    if (wr && m_idx == W * H) begin
                        m_frames = m_frames + 8'd1;
                        m_mode = M_ARMED;
                        mq.delete();
                    end else if (rise) begin
                        s_unf = 1'b1;
                        mq.delete();
                        m_mode = M_READY;
                    end
                end
                if (s_ovf) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
                if (s_unf) m_unf = 1'b1; else if (clr_err) m_unf = 1'b0;
                m_wr = wr;
                m_vbl_prev = pix_vblank;
                m_cyc++;
            end
        end
    end

    // Per-cycle comparison against the model, plus capture of write pulses.
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_n) begin
                chk("m_write", lcd_write, m_wr);
                chk("m_col", col_s, m_col);
                chk("m_vblank", lcd_vblank, (m_mode != M_STREAM));
                chk("m_active", frame_active, (m_mode == M_STREAM));
                chk("m_overflow", overflow, m_ovf);
                chk("m_underflow", underflow, m_unf);
                chk("m_frame_cnt", frame_cnt, m_frames);
                if (lcd_write === 1'b1) begin
                    wr_q.push_back(col_s);
                    wr_t.push_back(ncyc);
                end
            end
        end
    end

    // ---------------- per-cycle vector table ----------------
    typedef struct {
        logic       init;
        logic       vbl;
        logic       valid;
        logic [7:0] pix;
        logic       e_wr;
        logic [7:0] e_col;
        logic       e_vblank;
        logic       e_active;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   phase_left;
        logic vb;
        bit   burst;
        bit   found;

        // Reset held with toggling inputs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(i[0], i[1], 1'b1, {8'(i * 37), 8'(i * 11), 8'(i * 5)}, i[0]);
        end
        tick(1);
        chk("rst_write", lcd_write, 1'b0);
        chk("rst_col", col_s, 24'd0);
        chk("rst_vblank", lcd_vblank, 1'b1);
        chk("rst_active", frame_active, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 24'h123456, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("noinit_write", lcd_write, 1'b0);
            chk("noinit_active", frame_active, 1'b0);
        end

        // Table: walk the alignment sequence and the first two paced writes.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0};
        for (int r = 0; r < 12; r++) begin
            drive(vecs[r].init, vecs[r].vbl, vecs[r].valid, rgb(vecs[r].pix), 1'b0);
            tick(1);
            chk($sformatf("vec%0d_write", r), lcd_write, vecs[r].e_wr);
            chk($sformatf("vec%0d_col", r), col_s, rgb(vecs[r].e_col));
            chk($sformatf("vec%0d_vblank", r), lcd_vblank, vecs[r].e_vblank);
            chk($sformatf("vec%0d_active", r), frame_active, vecs[r].e_active);
        end

        // Single full frame, one pixel every 4 cycles.
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(2);
        drive(1'b1, 1'b1, 1'b0, 24'd0, 1'b0); tick(2);
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        chk("frame_start_active", frame_active, 1'b1);
        wr_q.delete(); wr_t.delete();
        send_pixels(8'h01, 8, 4);
        tick(12);
        chk("frame_writes", wr_q.size(), 8);
        for (int k = 0; k < wr_q.size() && k < 8; k++) begin
            chk("frame_col", wr_q[k], rgb(8'(k + 1)));
            if (k > 0) chk("frame_gap_ok", ((wr_t[k] - wr_t[k-1]) >= PIX), 1'b1);
        end
        chk("frame_cnt_1", frame_cnt, 8'd1);
        chk("frame_end_vblank", lcd_vblank, 1'b1);

        // Burst into a 4-deep FIFO while the pace timer is busy: 6th pixel dropped.
        drive(1'b1, 1'b1, 1'b0, 24'd0, 1'b0); tick(1);
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        wr_q.delete(); wr_t.delete();
        send_pixels(8'hA0, 1, 2);
        send_pixels(8'h31, 6, 1);
        tick(30);
        chk("burst_overflow", overflow, 1'b1);
        chk("burst_writes", wr_q.size(), 6);
        for (int k = 0; k < wr_q.size() && k < 6; k++) begin
            chk("burst_col", wr_q[k], (k == 0) ? rgb(8'hA0) : rgb(8'(8'h30 + k)));
        end
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b1); tick(1);
        chk("clr_overflow", overflow, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 24'd0, 1'b0); tick(1);
        chk("burst_short_underflow", underflow, 1'b1);
        chk("burst_frame_cnt", frame_cnt, 8'd1);

        // Short frame: vblank rises after 5 of 8 pixels, then a full frame.
        drive(1'b1, 1'b1, 1'b0, 24'd0, 1'b1); tick(1);
        chk("clr_underflow", underflow, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        wr_q.delete(); wr_t.delete();
        send_pixels(8'h41, 5, 4);
        tick(4);
        drive(1'b1, 1'b1, 1'b0, 24'd0, 1'b0); tick(1);
        chk("short_underflow", underflow, 1'b1);
        chk("short_writes", wr_q.size(), 5);
        chk("short_frame_cnt", frame_cnt, 8'd1);
        chk("short_vblank", lcd_vblank, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        wr_q.delete(); wr_t.delete();
        send_pixels(8'h51, 8, 4);
        tick(12);
        chk("resync_writes", wr_q.size(), 8);
        if (wr_q.size() > 0) chk("resync_first_col", wr_q[0], rgb(8'h51));
        chk("resync_frame_cnt", frame_cnt, 8'd2);

        // Driver init lost mid-frame.
        drive(1'b1, 1'b1, 1'b0, 24'd0, 1'b0); tick(1);
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        send_pixels(8'h61, 3, 1);
        drive(1'b0, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        for (int k = 0; k < 8; k++) begin
            chk("initdrop_write", lcd_write, 1'b0);
            chk("initdrop_vblank", lcd_vblank, 1'b1);
            tick(1);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, rgb(8'(8'h90 + k)), 1'b0); tick(1);
            chk("reinit_idle_active", frame_active, 1'b0);
            chk("reinit_idle_write", lcd_write, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, rgb(8'h99), 1'b0); tick(3);
        chk("reinit_after_rise", frame_active, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 24'd0, 1'b0); tick(1);
        chk("reinit_after_fall", frame_active, 1'b1);

        // Asynchronous reset while writes are pending.
        send_pixels(8'h71, 3, 1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk); #1;
            if (lcd_write === 1'b1) found = 1'b1;
        end
        chk("async_write_seen", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_write", lcd_write, 1'b0);
        chk("async_frame_cnt", frame_cnt, 8'd0);
        chk("async_vblank", lcd_vblank, 1'b1);
        chk("async_underflow", underflow, 1'b0);
        tick(2);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        vb = 1'b1;
        phase_left = 0;
        burst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (phase_left == 0) begin
                vb = !vb;
                phase_left = vb ? int'($urandom_range(2, 10)) : int'($urandom_range(10, 60));
                burst = ($urandom_range(0, 3) == 0);
            end
            phase_left--;
            drive(($urandom_range(0, 299) != 0), vb,
                  burst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0),
                  24'($urandom), ($urandom_range(0, 49) == 0));
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
